// File: rtl/nes_pad_emulator.sv
// Device-side NES pad responder: samples buttons while the host holds latch,
// then presents one active-low bit per accepted rising pulse edge on data.
module nes_pad_emulator #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       latch,
    input  logic       pulse,
    input  logic [7:0] buttons,
    output logic       data,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] shift_count
);

    localparam int         CH_LATCH  = 0;
    localparam int         CH_PULSE  = 1;
    localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [1:0]                  pin_s;
    logic [1:0][SYNC_STAGES-1:0] sync_r;
    logic [1:0]                  sync_s;
    logic [1:0]                  filt_r;
    logic [1:0]                  filt_d_r;
    logic [1:0][3:0]             run_r;
    logic                        latch_rise_s;
    logic                        latch_fall_s;
    logic                        pulse_rise_s;

    state_t                      state_r;
    logic [7:0]                  sr_r;
    logic                        busy_r;
    logic                        frame_done_r;
    logic [3:0]                  shift_count_r;

    assign pin_s[CH_LATCH] = latch;
    assign pin_s[CH_PULSE] = pulse;

    // Metastability chain for both host pins
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], pin_s[i]};
            end
        end
    end

    assign sync_s[CH_LATCH] = sync_r[CH_LATCH][SYNC_STAGES-1];
    assign sync_s[CH_PULSE] = sync_r[CH_PULSE][SYNC_STAGES-1];

    // Level filter: a new level must persist for FILTER_CYCLES cycles; any bounce restarts the run
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_r <= 2'b00;
            run_r  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_s[i] != filt_r[i]) begin
                    if (run_r[i] == FILT_LAST) begin
                        filt_r[i] <= sync_s[i];
                        run_r[i]  <= 4'd0;
                    end else begin
                        run_r[i]  <= run_r[i] + 4'd1;
                    end
                end else begin
                    run_r[i] <= 4'd0;
                end
            end
        end
    end

    // Previous filtered levels for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_d_r <= 2'b00;
        end else begin
            filt_d_r <= filt_r;
        end
    end

    assign latch_rise_s =  filt_r[CH_LATCH] & ~filt_d_r[CH_LATCH];
    assign latch_fall_s = ~filt_r[CH_LATCH] &  filt_d_r[CH_LATCH];
    assign pulse_rise_s =  filt_r[CH_PULSE] & ~filt_d_r[CH_PULSE];

    // Frame sequencer; a latch rise outranks everything, including a same-cycle pulse edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            sr_r          <= 8'hFF;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            shift_count_r <= 4'd0;
        end else begin
            frame_done_r <= 1'b0;
            if (latch_rise_s) begin
                state_r       <= ST_LOAD;
                sr_r          <= ~buttons;
                busy_r        <= 1'b0;
                shift_count_r <= 4'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_LOAD: begin
                        if (latch_fall_s) begin
                            state_r <= ST_SHIFT;
                            busy_r  <= 1'b1;
                        end else if (filt_r[CH_LATCH]) begin
                            sr_r <= ~buttons;
                        end else begin
                            sr_r <= sr_r;
                        end
                    end
                    ST_SHIFT: begin
                        if (pulse_rise_s) begin
                            // Zero shifts in behind the data, so DONE naturally drives 0
                            sr_r          <= {sr_r[6:0], 1'b0};
                            shift_count_r <= shift_count_r + 4'd1;
                            if (shift_count_r == 4'd7) begin
                                frame_done_r <= 1'b1;
                                busy_r       <= 1'b0;
                                state_r      <= ST_DONE;
                            end else begin
                                state_r <= ST_SHIFT;
                            end
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r       <= ST_IDLE;
                        sr_r          <= 8'hFF;
                        busy_r        <= 1'b0;
                        shift_count_r <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign data        = sr_r[7];
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign shift_count = shift_count_r;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Scenario bench for nes_pad_emulator: a queue of expected serial bits is filled
// when a frame is latched and drained as the host clocks each bit out.
module tb_nes_pad_emulator;

    logic       clk;
    logic       rst;
    logic       latch;
    logic       pulse;
    logic [7:0] buttons;
    logic       data;
    logic       busy;
    logic       frame_done;
    logic [3:0] shift_count;

    int total;
    int bad;
    int fd_count;
    int fd_long;
    logic fd_prev;
    logic sb[$];

    nes_pad_emulator #(.SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .latch      (latch),
        .pulse      (pulse),
        .buttons    (buttons),
        .data       (data),
        .busy       (busy),
        .frame_done (frame_done),
        .shift_count(shift_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: counts frame_done pulses and any that last longer than one cycle
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_count++;
            if (fd_prev === 1'b1) fd_long++;
        end
        fd_prev = frame_done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, summary follows");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] v);
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back(~v[7-i]);
    endtask

    task automatic do_latch(input int n);
        latch = 1'b1;
        wait_cycles(n);
        latch = 1'b0;
        wait_cycles(12);
    endtask

    task automatic do_pulse();
        pulse = 1'b1;
        wait_cycles(12);
        pulse = 1'b0;
        wait_cycles(12);
    endtask

    // Clocks n bits out, comparing each against the next scoreboard entry before its pulse
    task automatic shift_bits(input string tag, input int n, input int start, input bit scramble);
        logic exp_bit;
        for (int i = 0; i < n; i++) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL %s_sb_empty: bit %0d has no expected value", tag, start + i);
            end else begin
                exp_bit = sb.pop_front();
                if (data !== exp_bit) begin
                    bad++;
                    $display("FAIL %s_data bit %0d: got %b want %b", tag, start + i, data, exp_bit);
                end
            end
            do_pulse();
            if (scramble) buttons = 8'($urandom);
            total++;
            if (shift_count !== 4'(start + i + 1)) begin
                bad++;
                $display("FAIL %s_count after bit %0d: got %0d want %0d", tag, start + i, shift_count, start + i + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; latch = 1'b0; pulse = 1'b0; buttons = 8'h00;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        total++;
        if (data !== 1'b1 || busy !== 1'b0 || shift_count !== 4'd0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got data=%b busy=%b cnt=%0d fd=%b want 1 0 0 0", data, busy, shift_count, frame_done);
        end
        wait_cycles(50);
        total++;
        if (data !== 1'b1 || busy !== 1'b0 || shift_count !== 4'd0) begin
            bad++;
            $display("FAIL idle_hold: got data=%b busy=%b cnt=%0d want 1 0 0", data, busy, shift_count);
        end
        total++;
        if (fd_count !== 0) begin
            bad++;
            $display("FAIL idle_frame_done: got %0d strobes want 0", fd_count);
        end
    endtask

    task automatic test_frame();
        int fd0;
        fd0 = fd_count;
        buttons = 8'b1000_0001;
        do_latch(20);
        push_frame(buttons);
        total++;
        if (busy !== 1'b1 || shift_count !== 4'd0) begin
            bad++;
            $display("FAIL frame_start: got busy=%b cnt=%0d want 1 0", busy, shift_count);
        end
        shift_bits("frame", 7, 0, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL frame_busy_pre8: got %b want 1", busy);
        end
        shift_bits("frame", 1, 7, 1'b0);
        total++;
        if (data !== 1'b0 || busy !== 1'b0 || shift_count !== 4'd8) begin
            bad++;
            $display("FAIL frame_end: got data=%b busy=%b cnt=%0d want 0 0 8", data, busy, shift_count);
        end
        total++;
        if (fd_count !== fd0 + 1 || fd_long !== 0) begin
            bad++;
            $display("FAIL frame_done_strobe: got %0d strobes (%0d long) want 1 (0 long)", fd_count - fd0, fd_long);
        end
    endtask

    task automatic test_load_change();
        int fd0;
        fd0 = fd_count;
        buttons = 8'h00;
        latch = 1'b1;
        wait_cycles(10);
        buttons = 8'hFF;
        wait_cycles(10);
        latch = 1'b0;
        wait_cycles(12);
        push_frame(8'hFF);
        shift_bits("loadchg", 8, 0, 1'b1);
        total++;
        if (fd_count !== fd0 + 1 || data !== 1'b0) begin
            bad++;
            $display("FAIL loadchg_end: got strobes=%0d data=%b want 1 0", fd_count - fd0, data);
        end
    endtask

    task automatic test_abort();
        int fd0;
        buttons = 8'h81;
        do_latch(20);
        push_frame(buttons);
        shift_bits("abort_pre", 3, 0, 1'b0);
        fd0 = fd_count;
        buttons = 8'h80;
        latch = 1'b1;
        wait_cycles(12);
        total++;
        if (busy !== 1'b0 || shift_count !== 4'd0 || data !== 1'b0) begin
            bad++;
            $display("FAIL abort_load: got busy=%b cnt=%0d data=%b want 0 0 0", busy, shift_count, data);
        end
        latch = 1'b0;
        wait_cycles(12);
        total++;
        if (fd_count !== fd0 || busy !== 1'b1 || shift_count !== 4'd0) begin
            bad++;
            $display("FAIL abort_restart: got strobes=%0d busy=%b cnt=%0d want 0 1 0", fd_count - fd0, busy, shift_count);
        end
        push_frame(8'h80);
        shift_bits("abort_new", 8, 0, 1'b0);
        total++;
        if (fd_count !== fd0 + 1) begin
            bad++;
            $display("FAIL abort_new_done: got %0d strobes want 1", fd_count - fd0);
        end
    endtask

    task automatic test_bounce();
        int fd0;
        fd0 = fd_count;
        buttons = 8'h5A;
        do_latch(20);
        push_frame(buttons);
        repeat (5) begin
            pulse = 1'b1;
            wait_cycles(1);
            pulse = 1'b0;
            wait_cycles(3);
        end
        wait_cycles(10);
        total++;
        if (shift_count !== 4'd0 || data !== sb[0]) begin
            bad++;
            $display("FAIL bounce_glitch: got cnt=%0d data=%b want 0 %b", shift_count, data, sb[0]);
        end
        shift_bits("bounce", 8, 0, 1'b0);
        repeat (10) do_pulse();
        total++;
        if (shift_count !== 4'd8 || data !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_extra: got cnt=%0d data=%b busy=%b want 8 0 0", shift_count, data, busy);
        end
        total++;
        if (fd_count !== fd0 + 1) begin
            bad++;
            $display("FAIL done_extra_strobe: got %0d strobes want 1", fd_count - fd0);
        end
    endtask

    task automatic test_reset_mid();
        buttons = 8'h81;
        do_latch(20);
        push_frame(buttons);
        shift_bits("rstmid", 3, 0, 1'b0);
        rst = 1'b1;
        wait_cycles(1);
        total++;
        if (data !== 1'b1 || busy !== 1'b0 || shift_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: got data=%b busy=%b cnt=%0d want 1 0 0", data, busy, shift_count);
        end
        rst = 1'b0;
        do_pulse();
        total++;
        if (data !== 1'b1 || shift_count !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got data=%b cnt=%0d busy=%b want 1 0 0", data, shift_count, busy);
        end
    endtask

    initial begin
        total = 0; bad = 0; fd_count = 0; fd_long = 0; fd_prev = 1'b0;
        test_reset();
        test_frame();
        test_load_change();
        test_abort();
        test_bounce();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
